// File: rtl/ksv_perceptron_pkg.sv
// Shared ternary codes and sequencer state type for the perceptron datapath.
package ksv_perceptron_pkg;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_RSVD = 2'b10;

  localparam int unsigned TERN_FIELDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ternary_word_sanitizer.sv
// Maps reserved ternary fields to zero and flags that one was seen.
module ternary_word_sanitizer
  import ksv_perceptron_pkg::*;
(
  input  logic [7:0] word_in,
  output logic [7:0] word_out,
  output logic       rsvd_hit
);

  // Per-field substitution of the reserved code by TERN_ZERO.
  always_comb begin
    word_out = word_in;
    rsvd_hit = 1'b0;
    for (int unsigned k = 0; k < TERN_FIELDS; k++) begin
      if (word_in[2*k +: 2] == TERN_RSVD) begin
        word_out[2*k +: 2] = TERN_ZERO;
        rsvd_hit           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ternary_weight_sequencer.sv
// Stores a bank of packed ternary weight words and replays them, each held
// for STEP_CYCLES clocks, onto the perceptron weights input.
module ternary_weight_sequencer
  import ksv_perceptron_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter logic [23:0] STEP_CYCLES = 24'd10_000_000,
  parameter int unsigned IDX_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  input  logic             loop,
  input  logic             clear,
  output logic [7:0]       weights_out,
  output logic             weights_valid,
  output logic [IDX_W-1:0] word_idx,
  output logic [IDX_W:0]   word_count,
  output logic             busy,
  output logic             done,
  output logic             code_err
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(DEPTH);
  localparam logic [23:0]      STEP_LAST = STEP_CYCLES - 24'd1;

  seq_state_t       state;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [23:0]      step_cnt;
  logic [7:0]       mem [DEPTH];

  logic [7:0] clean_word;
  logic       rsvd_hit;
  logic       load_fire;

  ternary_word_sanitizer u_sanitizer (
    .word_in  (load_data),
    .word_out (clean_word),
    .rsvd_hit (rsvd_hit)
  );

  // Load port is open only while idle, not full and not being flushed.
  always_comb begin
    load_ready = (state == IDLE) && (word_count < CNT_FULL) && !clear;
    load_fire  = load_valid && load_ready;
  end

  assign busy     = (state == PLAY);
  assign word_idx = rd_ptr;

  // Weight bank write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= clean_word;
    end
  end

  // Control FSM with registered playback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      step_cnt      <= '0;
      weights_out   <= '0;
      weights_valid <= 1'b0;
      done          <= 1'b0;
      code_err      <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      word_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      step_cnt      <= '0;
      weights_out   <= '0;
      weights_valid <= 1'b0;
      done          <= 1'b0;
      code_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_fire) begin
        wr_ptr     <= wr_ptr + IDX_ONE;
        word_count <= word_count + CNT_ONE;
        if (rsvd_hit) begin
          code_err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start && (word_count != '0) && !load_fire) begin
            state         <= PLAY;
            rd_ptr        <= '0;
            step_cnt      <= '0;
            weights_out   <= mem[0];
            weights_valid <= 1'b1;
          end
        end
        PLAY: begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if ({1'b0, rd_ptr} < (word_count - CNT_ONE)) begin
              rd_ptr      <= rd_ptr + IDX_ONE;
              weights_out <= mem[rd_ptr + IDX_ONE];
            end else if (loop) begin
              rd_ptr      <= '0;
              weights_out <= mem[0];
            end else begin
              state         <= IDLE;
              rd_ptr        <= '0;
              weights_out   <= '0;
              weights_valid <= 1'b0;
              done          <= 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_weight_sequencer.sv
// Self-checking bench: a queue/array-level model of the sequencer compared
// against the DUT every cycle, plus literal expectations for directed cases.
module tb_ternary_weight_sequencer;

  localparam int DEPTH = 4;
  localparam int STEP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       start = 1'b0;
  logic       loop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] weights_out;
  logic       weights_valid;
  logic [1:0] word_idx;
  logic [2:0] word_count;
  logic       busy;
  logic       done;
  logic       code_err;

  int n_cmp = 0;
  int n_err = 0;

  ternary_weight_sequencer #(
    .DEPTH       (DEPTH),
    .STEP_CYCLES (24'd3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .start         (start),
    .loop          (loop),
    .clear         (clear),
    .weights_out   (weights_out),
    .weights_valid (weights_valid),
    .word_idx      (word_idx),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .code_err      (code_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: weights are a list of field values; reserved fields become zero.
  function automatic logic [7:0] sanitize(input logic [7:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      int f;
      f = (w >> (2 * k)) & 3;
      if (f != 2) r = r | 8'(f << (2 * k));
    end
    return r;
  endfunction

  function automatic bit has_rsvd(input logic [7:0] w);
    for (int k = 0; k < 4; k++) begin
      if (((w >> (2 * k)) & 3) == 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model state: stored list, count, whether playing, which word, how long held.
  logic [7:0] bank [DEPTH];
  int m_cnt  = 0;
  bit m_err  = 0;
  bit m_play = 0;
  int m_idx  = 0;
  int m_hold = 0;
  bit m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_err = 0; m_play = 0; m_idx = 0; m_hold = 0; m_done = 0;
    end else if (clear) begin
      m_cnt = 0; m_err = 0; m_play = 0; m_idx = 0; m_hold = 0; m_done = 0;
    end else begin
      bit fire;
      bit was_play;
      int old_cnt;
      was_play = m_play;
      old_cnt  = m_cnt;
      fire     = load_valid && !m_play && (m_cnt < DEPTH);
      m_done   = 0;
      if (fire) begin
        bank[m_cnt] = sanitize(load_data);
        m_cnt++;
        if (has_rsvd(load_data)) m_err = 1;
      end
      if (was_play) begin
        m_hold++;
        if (m_hold == STEP) begin
          m_hold = 0;
          if (m_idx + 1 < old_cnt) m_idx++;
          else if (loop) m_idx = 0;
          else begin
            m_play = 0; m_idx = 0; m_done = 1;
          end
        end
      end else if (start && old_cnt > 0 && !fire) begin
        m_play = 1; m_idx = 0; m_hold = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("load_ready", int'(load_ready), int'(!m_play && m_cnt < DEPTH && !clear));
      check("weights_valid", int'(weights_valid), int'(m_play));
      check("weights_out", int'(weights_out), m_play ? int'(bank[m_idx]) : 0);
      check("word_idx", int'(word_idx), m_play ? m_idx : 0);
      check("word_count", int'(word_count), m_cnt);
      check("busy", int'(busy), int'(m_play));
      check("done", int'(done), int'(m_done));
      check("code_err", int'(code_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load_data  = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] seq1 [9] = '{8'h15, 8'h15, 8'h15, 8'hFF, 8'hFF, 8'hFF, 8'h4D, 8'h4D, 8'h4D};

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_count", int'(word_count), 0);
    check("rst_valid", int'(weights_valid), 0);
    check("rst_err", int'(code_err), 0);

    // 1: three-word non-looping playback.
    load_word(8'h15); load_word(8'hFF); load_word(8'h4D);
    check("s1_count", int'(word_count), 3);
    check("s1_ready", int'(load_ready), 1);
    loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check("s1_seq", int'(weights_out), int'(seq1[i]));
      tick();
    end
    check("s1_done", int'(done), 1);
    check("s1_valid_end", int'(weights_valid), 0);
    tick();
    check("s1_done_once", int'(done), 0);

    // 2: reserved code sanitised and sticky error.
    pulse_clear();
    load_word(8'hAA);
    check("s2_err", int'(code_err), 1);
    load_word(8'h01);
    check("s2_err_sticky", int'(code_err), 1);
    pulse_start();
    check("s2_sanitized", int'(weights_out), 8'h00);
    tick(); tick(); tick();
    check("s2_second", int'(weights_out), 8'h01);
    pulse_clear();
    check("s2_clr_err", int'(code_err), 0);
    check("s2_clr_cnt", int'(word_count), 0);

    // 3: fill past capacity, then loop playback.
    load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_data = 8'($urandom);
      tick();
      if (i == 3) check("s3_full_ready", int'(load_ready), 0);
    end
    load_valid = 1'b0;
    check("s3_count", int'(word_count), 4);
    loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      check("s3_idx", int'(word_idx), (i / STEP) % DEPTH);
      check("s3_nodone", int'(done), 0);
      tick();
    end
    pulse_clear();

    // 4: ignored starts.
    pulse_start();
    check("s4_empty_start", int'(busy), 0);
    load_word(8'h05); load_word(8'h31);
    loop = 1'b0;
    pulse_start();
    tick();
    pulse_start();
    repeat (6) tick();
    pulse_clear();
    load_data = 8'h0C; load_valid = 1'b1; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    check("s4_ld_start_busy", int'(busy), 0);
    check("s4_ld_start_cnt", int'(word_count), 1);

    // 5: asynchronous reset during second word.
    load_word(8'h41);
    pulse_start();
    repeat (4) tick();
    check("s5_pre_idx", int'(word_idx), 1);
    rst_n = 1'b0;
    #1;
    check("s5_valid", int'(weights_valid), 0);
    check("s5_out", int'(weights_out), 0);
    check("s5_busy", int'(busy), 0);
    check("s5_done", int'(done), 0);
    tick(); tick();
    rst_n = 1'b1;
    check("s5_count", int'(word_count), 0);

    // 6: clear during looping playback, then reload.
    load_word(8'h1D); load_word(8'h37);
    loop = 1'b1;
    pulse_start();
    repeat (4) tick();
    check("s6_idx", int'(word_idx), 1);
    pulse_clear();
    check("s6_busy", int'(busy), 0);
    check("s6_valid", int'(weights_valid), 0);
    check("s6_done", int'(done), 0);
    load_word(8'hD3);
    check("s6_reload_cnt", int'(word_count), 1);
    pulse_start();
    check("s6_reload_word", int'(weights_out), 8'hD3);
    loop = 1'b0;
    repeat (4) tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = 8'($urandom);
      start      = ($urandom_range(0, 9) == 0);
      loop       = ($urandom_range(0, 1) == 1);
      clear      = ($urandom_range(0, 39) == 0);
      tick();
    end
    load_valid = 1'b0; start = 1'b0; clear = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
